hilo_unit: RTL and testbench

- Owns the architectural HI/LO register pair directly downstream of the multiply/divide ALU.
- Commits mult/div results, executes software MTHI/MTLO writes, and serves MFHI/MFLO reads with bypass.
- Tracks one in-flight mult/div operation and raises a stall when a read depends on it.
- Decides per-half whether a late arithmetic result is discarded; issues an annul back to the ALU.

---
 rtl/hilo_unit_pkg.sv | 13 +
 rtl/hilo_bypass.sv | 54 +++++
 rtl/hilo_unit.sv | 109 ++++++++++
 tb/tb_hilo_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_unit_pkg.sv
// Shared definitions for the HI/LO register pair: data width, FSM states, reset value.
package hilo_unit_pkg;

    localparam int HILO_DW = 32;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } hiloState_t;

    localparam logic [HILO_DW-1:0] HILO_RESET = '0;

endpackage

// File: rtl/hilo_bypass.sv
// Combinational MFHI/MFLO read path: forwards in-flight MTHI/MTLO data or a completing
// mult/div result, and flags a stall when the read depends on a result not yet available.
module hilo_bypass #(
    parameter int DW = hilo_unit_pkg::HILO_DW
) (
    input  logic          busy,
    input  logic          hiWr,
    input  logic          loWr,
    input  logic          md_ready,
    input  logic [2*DW-1:0] md_result,
    input  logic          mthiM,
    input  logic          mtloM,
    input  logic [DW-1:0] wdataM,
    input  logic          mfhiE,
    input  logic          mfloE,
    input  logic [DW-1:0] hi,
    input  logic [DW-1:0] lo,
    output logic [DW-1:0] rdataE,
    output logic          stallE
);

    logic [DW-1:0] hiView;
    logic [DW-1:0] loView;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        hiView = hi;
        loView = lo;
        if (mthiM)
            hiView = wdataM;
        else if (busy && md_ready && !hiWr)
            hiView = md_result[2*DW-1:DW];
        if (mtloM)
            loView = wdataM;
        else if (busy && md_ready && !loWr)
            loView = md_result[DW-1:0];

        rdataE = '0;
        if (mfhiE)
            rdataE = hiView;
        else if (mfloE)
            rdataE = loView;

        stallE = busy && !md_ready &&
                 ((mfhiE && !hiWr && !mthiM) || (mfloE && !loWr && !mtloM));
    end

    // A single E-stage instruction cannot be both MFHI and MFLO.
    always_comb begin
        assert (!(mfhiE && mfloE))
            else $error("hilo_bypass: mfhiE and mfloE asserted together");
    end

endmodule

// File: rtl/hilo_unit.sv
// Architectural HI/LO registers: commits mult/div results, applies MTHI/MTLO, tracks the
// one in-flight operation and tells the ALU to annul results that can no longer land.
module hilo_unit
    import hilo_unit_pkg::*;
#(
    parameter int DW = HILO_DW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            md_start,
    input  logic            md_ready,
    input  logic [2*DW-1:0] md_result,
    input  logic            flushM,
    input  logic            mthiM,
    input  logic            mtloM,
    input  logic [DW-1:0]   wdataM,
    input  logic            mfhiE,
    input  logic            mfloE,
    output logic [DW-1:0]   rdataE,
    output logic            stallE,
    output logic            annul_o,
    output logic            busy_o,
    output logic [DW-1:0]   hi_o,
    output logic [DW-1:0]   lo_o
);

    hiloState_t state;
    logic       hiWr;
    logic       loWr;
    logic       mtAllowed;
    logic       hiNext;
    logic       loNext;

    assign busy_o    = (state == BUSY);
    // A flushed MTHI/MTLO must not reach the registers while an op is in flight.
    assign mtAllowed = !(busy_o && flushM);
    assign hiNext    = hiWr || mthiM;
    assign loNext    = loWr || mtloM;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            hi_o    <= DW'(HILO_RESET);
            lo_o    <= DW'(HILO_RESET);
            hiWr    <= 1'b0;
            loWr    <= 1'b0;
            annul_o <= 1'b0;
        end else begin
            annul_o <= 1'b0;
            if (mthiM && mtAllowed)
                hi_o <= wdataM;
            if (mtloM && mtAllowed)
                lo_o <= wdataM;

            case (state)
                IDLE: begin
                    if (md_start) begin
                        state <= BUSY;
                        hiWr  <= 1'b0;
                        loWr  <= 1'b0;
                    end
                end
                BUSY: begin
                    if (flushM) begin
                        annul_o <= 1'b1;
                        state   <= IDLE;
                    end else if (md_start) begin
                        annul_o <= 1'b1;
                        hiWr    <= 1'b0;
                        loWr    <= 1'b0;
                    end else if (md_ready) begin
                        if (!hiNext)
                            hi_o <= md_result[2*DW-1:DW];
                        if (!loNext)
                            lo_o <= md_result[DW-1:0];
                        state <= IDLE;
                    end else if (hiNext && loNext) begin
                        // Software overwrote both halves: the result is dead on arrival.
                        annul_o <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        hiWr <= hiNext;
                        loWr <= loNext;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    hilo_bypass #(.DW(DW)) u_bypass (
        .busy      (busy_o),
        .hiWr      (hiWr),
        .loWr      (loWr),
        .md_ready  (md_ready),
        .md_result (md_result),
        .mthiM     (mthiM),
        .mtloM     (mtloM),
        .wdataM    (wdataM),
        .mfhiE     (mfhiE),
        .mfloE     (mfloE),
        .hi        (hi_o),
        .lo        (lo_o),
        .rdataE    (rdataE),
        .stallE    (stallE)
    );

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: directed scenarios plus randomized traffic against
// a behavioural model of the HI/LO pair and its in-flight operation.
module tb_hilo_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        md_start, md_ready, flushM, mthiM, mtloM, mfhiE, mfloE;
    logic [63:0] md_result;
    logic [31:0] wdataM;
    logic [31:0] rdataE, hi_o, lo_o;
    logic        stallE, annul_o, busy_o;

    int nTests = 0;
    int nFail  = 0;

    // Behavioural model state
    bit          mBusy, mHiWr, mLoWr, mAnnul;
    logic [31:0] mHi, mLo;
    bit          checking = 0;

    always #5 clk = ~clk;

    hilo_unit #(.DW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .md_start  (md_start),
        .md_ready  (md_ready),
        .md_result (md_result),
        .flushM    (flushM),
        .mthiM     (mthiM),
        .mtloM     (mtloM),
        .wdataM    (wdataM),
        .mfhiE     (mfhiE),
        .mfloE     (mfloE),
        .rdataE    (rdataE),
        .stallE    (stallE),
        .annul_o   (annul_o),
        .busy_o    (busy_o),
        .hi_o      (hi_o),
        .lo_o      (lo_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clearIn();
        rst = 0; md_start = 0; md_ready = 0; flushM = 0;
        mthiM = 0; mtloM = 0; mfhiE = 0; mfloE = 0;
        md_result = '0; wdataM = '0;
    endtask

    // First half of a cycle: settle at the falling edge and compare against the model.
    task automatic half();
        logic [31:0] expR;
        bit          expStall;
        @(negedge clk);
        if (!checking) return;
        expR = 32'h0;
        if (mfhiE)
            expR = mthiM ? wdataM : (mBusy && md_ready && !mHiWr) ? md_result[63:32] : mHi;
        else if (mfloE)
            expR = mtloM ? wdataM : (mBusy && md_ready && !mLoWr) ? md_result[31:0] : mLo;
        expStall = mBusy && !md_ready &&
                   ((mfhiE && !mHiWr && !mthiM) || (mfloE && !mLoWr && !mtloM));
        check("hi_o",    {32'h0, hi_o}, {32'h0, mHi});
        check("lo_o",    {32'h0, lo_o}, {32'h0, mLo});
        check("busy_o",  {63'h0, busy_o}, {63'h0, mBusy});
        check("annul_o", {63'h0, annul_o}, {63'h0, mAnnul});
        if (!rst) begin
            check("rdataE", {32'h0, rdataE}, {32'h0, expR});
            check("stallE", {63'h0, stallE}, {63'h0, expStall});
        end
    endtask

    // Second half: advance the model by the rules, then take the clock edge.
    task automatic fin();
        bit          nBusy, nHiWr, nLoWr, nAnnul, hw, lw;
        logic [31:0] nHi, nLo;
        nBusy = mBusy; nHiWr = mHiWr; nLoWr = mLoWr; nHi = mHi; nLo = mLo; nAnnul = 0;
        if (rst) begin
            nBusy = 0; nHiWr = 0; nLoWr = 0; nHi = 0; nLo = 0;
        end else if (mBusy && flushM) begin
            nAnnul = 1; nBusy = 0;
        end else begin
            if (mthiM) nHi = wdataM;
            if (mtloM) nLo = wdataM;
            hw = mHiWr || mthiM;
            lw = mLoWr || mtloM;
            if (!mBusy) begin
                if (md_start) begin nBusy = 1; nHiWr = 0; nLoWr = 0; end
            end else if (md_start) begin
                nAnnul = 1; nHiWr = 0; nLoWr = 0;
            end else if (md_ready) begin
                if (!hw) nHi = md_result[63:32];
                if (!lw) nLo = md_result[31:0];
                nBusy = 0;
            end else if (hw && lw) begin
                nAnnul = 1; nBusy = 0;
            end else begin
                nHiWr = hw; nLoWr = lw;
            end
        end
        @(posedge clk);
        #1;
        mBusy = nBusy; mHiWr = nHiWr; mLoWr = nLoWr; mHi = nHi; mLo = nLo; mAnnul = nAnnul;
    endtask

    task automatic tick();
        half();
        fin();
        clearIn();
    endtask

    logic [31:0] savedHi, savedLo;
    int          r;

    initial begin
        clearIn();
        rst = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mBusy = 0; mHiWr = 0; mLoWr = 0; mHi = 0; mLo = 0; mAnnul = 0;
        checking = 1;
        tick();                               // rst still high one more cycle
        check("rst_hi", {32'h0, hi_o}, 64'h0);
        check("rst_busy", {63'h0, busy_o}, 64'h0);
        check("rst_annul", {63'h0, annul_o}, 64'h0);

        // Basic completion
        md_start = 1; tick();
        tick(); tick();
        md_ready = 1; md_result = 64'h00000001_FFFFFFFE; tick();
        check("t1_hi", {32'h0, hi_o}, 64'h1);
        check("t1_lo", {32'h0, lo_o}, 64'hFFFFFFFE);
        check("t1_busy", {63'h0, busy_o}, 64'h0);

        // MFHI stalls until the result arrives, then bypasses it
        md_start = 1; tick();
        for (int i = 0; i < 3; i++) begin
            mfhiE = 1; half();
            check("t2_stall", {63'h0, stallE}, 64'h1);
            fin(); clearIn();
        end
        mfhiE = 1; md_ready = 1; md_result = 64'hCAFEF00D_0BADBEEF; half();
        check("t2_byp", {32'h0, rdataE}, 64'hCAFEF00D);
        check("t2_nostall", {63'h0, stallE}, 64'h0);
        fin(); clearIn();

        // MTHI during the op keeps HI, LO still takes the result
        md_start = 1; tick();
        mthiM = 1; wdataM = 32'hAAAA5555; tick();
        md_ready = 1; md_result = 64'h12345678_9ABCDEF0; tick();
        check("t3_hi", {32'h0, hi_o}, 64'hAAAA5555);
        check("t3_lo", {32'h0, lo_o}, 64'h9ABCDEF0);

        // Both halves overwritten -> annul
        md_start = 1; tick();
        mthiM = 1; wdataM = 32'h11; tick();
        mtloM = 1; wdataM = 32'h22; tick();
        check("t4_annul", {63'h0, annul_o}, 64'h1);
        check("t4_busy", {63'h0, busy_o}, 64'h0);
        md_ready = 1; md_result = 64'hFFFFFFFF_FFFFFFFF; tick();
        check("t4_hi", {32'h0, hi_o}, 64'h11);
        check("t4_lo", {32'h0, lo_o}, 64'h22);
        check("t4_annul_end", {63'h0, annul_o}, 64'h0);

        // Flush abandons the op, HI/LO hold, MTHI in the flush cycle is dropped
        savedHi = hi_o; savedLo = lo_o;
        md_start = 1; tick();
        flushM = 1; mthiM = 1; wdataM = 32'h5A5A5A5A; tick();
        check("t5_annul", {63'h0, annul_o}, 64'h1);
        check("t5_busy", {63'h0, busy_o}, 64'h0);
        check("t5_hi", {32'h0, hi_o}, {32'h0, savedHi});
        check("t5_lo", {32'h0, lo_o}, {32'h0, savedLo});
        tick();
        md_start = 1; tick();
        md_ready = 1; md_result = 64'h0000BEEF_0000CAFE; tick();
        check("t5_hi2", {32'h0, hi_o}, 64'hBEEF);
        check("t5_lo2", {32'h0, lo_o}, 64'hCAFE);

        // New op while busy: annul, stay busy, same-cycle result dropped
        md_start = 1; tick();
        md_start = 1; md_ready = 1; md_result = 64'h1; tick();
        check("t7_annul", {63'h0, annul_o}, 64'h1);
        check("t7_busy", {63'h0, busy_o}, 64'h1);
        md_ready = 1; md_result = 64'h00000007_00000008; tick();
        check("t7_hi", {32'h0, hi_o}, 64'h7);

        // MTLO bypass in IDLE
        mtloM = 1; wdataM = 32'hDEADBEEF; mfloE = 1; half();
        check("t6_rd", {32'h0, rdataE}, 64'hDEADBEEF);
        check("t6_stall", {63'h0, stallE}, 64'h0);
        fin(); clearIn();
        check("t6_lo", {32'h0, lo_o}, 64'hDEADBEEF);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 99));
            md_start  = ($urandom_range(0, 99) < 15);
            md_ready  = mBusy ? ($urandom_range(0, 99) < 25) : ($urandom_range(0, 99) < 3);
            md_result = {$urandom, $urandom};
            flushM    = mBusy && ($urandom_range(0, 99) < 6);
            mthiM     = ($urandom_range(0, 99) < 15);
            mtloM     = ($urandom_range(0, 99) < 15);
            wdataM    = $urandom;
            mfhiE     = (r < 25);
            mfloE     = (r >= 25) && (r < 50);
            rst       = ($urandom_range(0, 999) < 5);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
